// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage hazard interface: instruction attributes from ID towards the
// scoreboard, and stall/bubble/status signals coming back.
interface id_hazard_scoreboard_if;
    logic        ID_valid;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_rs_used;
    logic        ID_rt_used;
    logic [4:0]  ID_Wesel;
    logic        ID_RegWrite;
    logic        ID_MemRead;
    logic        ID_MulDiv;
    logic        ID_ReadHiLo;
    logic        ID_Flush;
    logic        ID_Stall;
    logic        EX_Bubble;
    logic        MulDiv_Busy;
    logic [15:0] Stall_Count;

    modport master (
        output ID_valid, ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_Wesel,
               ID_RegWrite, ID_MemRead, ID_MulDiv, ID_ReadHiLo, ID_Flush,
        input  ID_Stall, EX_Bubble, MulDiv_Busy, Stall_Count
    );

    modport slave (
        input  ID_valid, ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_Wesel,
               ID_RegWrite, ID_MemRead, ID_MulDiv, ID_ReadHiLo, ID_Flush,
        output ID_Stall, EX_Bubble, MulDiv_Busy, Stall_Count
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Register/HI-LO hazard scoreboard for the ID stage: tracks per-register
// forwarding readiness and mult/div occupancy, and stalls dependent issues.
module id_hazard_scoreboard #(
    parameter int unsigned MULDIV_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    id_hazard_scoreboard_if.slave  bus
);

    localparam logic [5:0] LatVal = 6'(MULDIV_LAT);

    logic [1:0]  pend_q [32];
    logic [1:0]  pend_d [32];
    logic [5:0]  busy_q, busy_d;
    logic [15:0] stallCnt_q, stallCnt_d;

    logic rawHazard;
    logic hiloHazard;
    logic stall;
    logic issue;

    assign rawHazard = (bus.ID_rs_used && (bus.ID_rs != 5'd0) && (pend_q[bus.ID_rs] != 2'd0)) ||
                       (bus.ID_rt_used && (bus.ID_rt != 5'd0) && (pend_q[bus.ID_rt] != 2'd0));
    assign hiloHazard = (busy_q != 6'd0) && (bus.ID_ReadHiLo || bus.ID_MulDiv);
    assign stall      = bus.ID_valid && !bus.ID_Flush && (rawHazard || hiloHazard);
    assign issue      = bus.ID_valid && !bus.ID_Flush && !stall;

    assign bus.ID_Stall    = stall;
    assign bus.EX_Bubble   = stall;
    assign bus.MulDiv_Busy = (busy_q != 6'd0);
    assign bus.Stall_Count = stallCnt_q;

    // The issuing writer replaces whatever countdown its destination had,
    // so a younger ALU write can shorten an older load's wait.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = (pend_q[i] != 2'd0) ? (pend_q[i] - 2'd1) : 2'd0;
        end
        if (issue && bus.ID_RegWrite && (bus.ID_Wesel != 5'd0)) begin
            pend_d[bus.ID_Wesel] = bus.ID_MemRead ? 2'd2 : 2'd1;
        end
        pend_d[0] = 2'd0;

        busy_d = (busy_q != 6'd0) ? (busy_q - 6'd1) : 6'd0;
        if (issue && bus.ID_MulDiv) begin
            busy_d = LatVal;
        end

        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= 2'd0;
            end
            busy_q     <= 6'd0;
            stallCnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
            busy_q     <= busy_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed, table-driven bench for id_hazard_scoreboard: one vector per cycle
// with hand-computed stall/busy/count expectations, plus reset and saturation sequences.
module tb_id_hazard_scoreboard;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        rsUsed;
        logic [4:0]  rt;
        logic        rtUsed;
        logic [4:0]  wesel;
        logic        regWrite;
        logic        memRead;
        logic        mulDiv;
        logic        readHiLo;
        logic        flush;
        logic        expStall;
        logic        expBusy;
        logic [15:0] expCount;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs[$];

    id_hazard_scoreboard_if bus();

    id_hazard_scoreboard #(.MULDIV_LAT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic rsUsed,
                                input logic [4:0] rt, input logic rtUsed, input logic [4:0] wesel,
                                input logic regWrite, input logic memRead, input logic mulDiv,
                                input logic readHiLo, input logic flush, input logic expStall,
                                input logic expBusy, input logic [15:0] expCount);
        vec_t v;
        v.valid = valid;  v.rs = rs;  v.rsUsed = rsUsed;  v.rt = rt;  v.rtUsed = rtUsed;
        v.wesel = wesel;  v.regWrite = regWrite;  v.memRead = memRead;  v.mulDiv = mulDiv;
        v.readHiLo = readHiLo;  v.flush = flush;  v.expStall = expStall;
        v.expBusy = expBusy;  v.expCount = expCount;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.ID_valid    = v.valid;
        bus.ID_rs       = v.rs;
        bus.ID_rs_used  = v.rsUsed;
        bus.ID_rt       = v.rt;
        bus.ID_rt_used  = v.rtUsed;
        bus.ID_Wesel    = v.wesel;
        bus.ID_RegWrite = v.regWrite;
        bus.ID_MemRead  = v.memRead;
        bus.ID_MulDiv   = v.mulDiv;
        bus.ID_ReadHiLo = v.readHiLo;
        bus.ID_Flush    = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("vec%0d ID_Stall", idx), 16'(bus.ID_Stall), 16'(v.expStall));
        checkOutput($sformatf("vec%0d EX_Bubble", idx), 16'(bus.EX_Bubble), 16'(v.expStall));
        checkOutput($sformatf("vec%0d MulDiv_Busy", idx), 16'(bus.MulDiv_Busy), 16'(v.expBusy));
        checkOutput($sformatf("vec%0d Stall_Count", idx), bus.Stall_Count, v.expCount);
    endtask

    initial begin
        vec_t idle;
        errors = 0;
        checks = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        // Fields: valid rs rsU rt rtU wesel rw mr md hilo flush | stall busy count
        vecs.push_back(mk(0,  0,0, 0,0,  0,0,0,0,0,0, 0,0,16'd0));
        // ALU producer then immediate reader: one stall cycle
        vecs.push_back(mk(1,  0,0, 0,0,  3,1,0,0,0,0, 0,0,16'd0));
        vecs.push_back(mk(1,  3,1, 1,1,  8,1,0,0,0,0, 1,0,16'd0));
        vecs.push_back(mk(1,  3,1, 1,1,  8,1,0,0,0,0, 0,0,16'd1));
        vecs.push_back(mk(0,  0,0, 0,0,  0,0,0,0,0,0, 0,0,16'd1));
        // Load producer then reader via rt: two stall cycles
        vecs.push_back(mk(1,  0,0, 0,0,  5,1,1,0,0,0, 0,0,16'd1));
        vecs.push_back(mk(1,  0,0, 5,1,  0,0,0,0,0,0, 1,0,16'd1));
        vecs.push_back(mk(1,  0,0, 5,1,  0,0,0,0,0,0, 1,0,16'd2));
        vecs.push_back(mk(1,  0,0, 5,1,  0,0,0,0,0,0, 0,0,16'd3));
        // Load, unrelated instruction, reader: one stall cycle
        vecs.push_back(mk(1,  0,0, 0,0,  5,1,1,0,0,0, 0,0,16'd3));
        vecs.push_back(mk(1,  1,1, 0,0,  9,1,0,0,0,0, 0,0,16'd3));
        vecs.push_back(mk(1,  0,0, 5,1,  0,0,0,0,0,0, 1,0,16'd3));
        vecs.push_back(mk(1,  0,0, 5,1,  0,0,0,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(0,  0,0, 0,0,  0,0,0,0,0,0, 0,0,16'd4));
        // Register 0 and unused source never stall
        vecs.push_back(mk(1,  0,0, 0,0,  0,1,0,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(1,  0,1, 0,1,  0,0,0,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(1,  0,0, 0,0,  6,1,1,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(1,  6,0, 0,1,  0,0,0,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(0,  0,0, 0,0,  0,0,0,0,0,0, 0,0,16'd4));
        // Invalid slot never stalls, real reader does
        vecs.push_back(mk(1,  0,0, 0,0, 10,1,1,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(0, 10,1, 0,0,  0,0,0,0,0,0, 0,0,16'd4));
        vecs.push_back(mk(1, 10,1, 0,0,  0,0,0,0,0,0, 1,0,16'd4));
        vecs.push_back(mk(1, 10,1, 0,0,  0,0,0,0,0,0, 0,0,16'd5));
        // Younger ALU writer overrides older load countdown
        vecs.push_back(mk(1,  0,0, 0,0,  7,1,1,0,0,0, 0,0,16'd5));
        vecs.push_back(mk(1,  0,0, 0,0,  7,1,0,0,0,0, 0,0,16'd5));
        vecs.push_back(mk(1,  7,1, 0,0,  0,0,0,0,0,0, 1,0,16'd5));
        vecs.push_back(mk(1,  7,1, 0,0,  0,0,0,0,0,0, 0,0,16'd6));
        // Flush beats stall and leaves the scoreboard untouched
        vecs.push_back(mk(1,  0,0, 0,0, 11,1,0,0,0,0, 0,0,16'd6));
        vecs.push_back(mk(1, 11,1, 0,0, 12,1,1,0,0,1, 0,0,16'd6));
        vecs.push_back(mk(1, 12,1, 0,0,  0,0,0,0,0,0, 0,0,16'd6));
        vecs.push_back(mk(1,  0,0, 0,0, 13,1,1,0,0,0, 0,0,16'd6));
        vecs.push_back(mk(1, 13,1, 0,0,  0,0,0,0,0,1, 0,0,16'd6));
        vecs.push_back(mk(1, 13,1, 0,0,  0,0,0,0,0,0, 1,0,16'd6));
        vecs.push_back(mk(1, 13,1, 0,0,  0,0,0,0,0,0, 0,0,16'd7));
        // Stalled mult must not start the busy counter
        vecs.push_back(mk(1,  0,0, 0,0, 16,1,0,0,0,0, 0,0,16'd7));
        vecs.push_back(mk(1, 16,1, 0,0,  0,0,0,1,0,0, 1,0,16'd7));
        vecs.push_back(mk(1, 16,1, 0,0,  0,0,0,1,0,0, 0,0,16'd8));
        // mflo behind the mult: eight stall cycles, busy drops with the release
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1, 0,0, 0,0, 0,0,0,0,1,0, 1,1,16'(8 + k)));
        end
        vecs.push_back(mk(1,  0,0, 0,0,  0,0,0,0,1,0, 0,0,16'd16));
        vecs.push_back(mk(0,  0,0, 0,0,  0,0,0,0,0,0, 0,0,16'd16));

        applyStimulus(idle);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
        end

        // Reset in the middle of a load countdown and a mult
        @(negedge clk);
        applyStimulus(mk(1, 0,0, 0,0, 20,1,1,1,0,0, 0,0,16'd16));
        @(negedge clk);
        checkOutput("busy before reset", 16'(bus.MulDiv_Busy), 16'd1);
        applyStimulus(idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(1, 20,1, 0,0, 0,0,0,0,1,0, 0,0,16'd0));
        #1;
        checkOutput("post-reset ID_Stall", 16'(bus.ID_Stall), 16'd0);
        checkOutput("post-reset EX_Bubble", 16'(bus.EX_Bubble), 16'd0);
        checkOutput("post-reset MulDiv_Busy", 16'(bus.MulDiv_Busy), 16'd0);
        checkOutput("post-reset Stall_Count", bus.Stall_Count, 16'd0);

        // Back-to-back mults: 8 stalls in every 9 cycles until the counter saturates
        @(negedge clk);
        applyStimulus(idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(1, 0,0, 0,0, 0,0,0,1,0,0, 0,0,16'd0));
        repeat (90) @(posedge clk);
        #1;
        checkOutput("count after 90 cycles", bus.Stall_Count, 16'd80);
        repeat (74910) @(posedge clk);
        #1;
        checkOutput("count saturated", bus.Stall_Count, 16'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("count held at max", bus.Stall_Count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
